// File: rtl/switch_debounce.sv
// Synchronises and debounces the slide-switch vector (as one group) and the confirm
// button, producing a stable switch value, a one-cycle confirm pulse and a sticky flag.
//
// state          | meaning
// ---------------+-----------------------------------------------------------
// ST_IDLE        | button released and settled, waiting for a press
// ST_PRESS_WAIT  | button seen high, counting the stable-high window
// ST_PRESSED     | press accepted (pulse issued), waiting for release
// ST_RELEASE_WAIT| button seen low, counting the stable-low window
module switch_debounce #(
    parameter int WIDTH     = 16,
    parameter int DB_CYCLES = 200000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    input  logic             btn_raw,
    input  logic             ack,
    output logic [WIDTH-1:0] sw_stable,
    output logic             confirm_pulse,
    output logic             confirm_pending
);

    localparam int            CW      = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_WAIT,
        ST_PRESSED,
        ST_RELEASE_WAIT
    } state_t;

    logic [WIDTH-1:0] r_sw_s1;
    logic [WIDTH-1:0] r_sw_s2;
    logic             r_btn_s1;
    logic             r_btn_s2;
    logic [WIDTH-1:0] r_cand;
    logic [CW-1:0]    r_sw_cnt;
    logic [WIDTH-1:0] r_sw_stable;
    state_t           r_state;
    logic [CW-1:0]    r_btn_cnt;
    logic             r_confirm_pulse;
    logic             r_confirm_pending;

    assign sw_stable       = r_sw_stable;
    assign confirm_pulse   = r_confirm_pulse;
    assign confirm_pending = r_confirm_pending;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
            r_btn_s1 <= 1'b0;
            r_btn_s2 <= 1'b0;
        end else begin
            r_sw_s1  <= sw_raw;
            r_sw_s2  <= r_sw_s1;
            r_btn_s1 <= btn_raw;
            r_btn_s2 <= r_btn_s1;
        end
    end

    // Any bit change restarts the whole window; the counter saturates so the
    // commit simply repeats with the same value while the input stays put.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cand      <= '0;
            r_sw_cnt    <= '0;
            r_sw_stable <= '0;
        end else if (r_sw_s2 != r_cand) begin
            r_cand   <= r_sw_s2;
            r_sw_cnt <= '0;
        end else if (r_sw_cnt == CNT_MAX) begin
            r_sw_stable <= r_cand;
        end else begin
            r_sw_cnt <= r_sw_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= ST_IDLE;
            r_btn_cnt       <= '0;
            r_confirm_pulse <= 1'b0;
        end else begin
            r_confirm_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_btn_s2) begin
                        r_state   <= ST_PRESS_WAIT;
                        r_btn_cnt <= '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!r_btn_s2) begin
                        r_state <= ST_IDLE;
                    end else if (r_btn_cnt == CNT_MAX) begin
                        r_state         <= ST_PRESSED;
                        r_confirm_pulse <= 1'b1;
                    end else begin
                        r_btn_cnt <= r_btn_cnt + CNT_ONE;
                    end
                end
                ST_PRESSED: begin
                    if (!r_btn_s2) begin
                        r_state   <= ST_RELEASE_WAIT;
                        r_btn_cnt <= '0;
                    end
                end
                ST_RELEASE_WAIT: begin
                    // A bounce back high during release is the same press: no new pulse.
                    if (r_btn_s2) begin
                        r_state <= ST_PRESSED;
                    end else if (r_btn_cnt == CNT_MAX) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_btn_cnt <= r_btn_cnt + CNT_ONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_confirm_pending <= 1'b0;
        end else if (r_confirm_pulse) begin
            r_confirm_pending <= 1'b1;
        end else if (ack) begin
            r_confirm_pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with a short debounce window (DB_CYCLES=4).
module tb_switch_debounce;

    localparam int WIDTH = 16;
    localparam int DB    = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] sw_raw;
    logic             btn_raw;
    logic             ack;
    logic [WIDTH-1:0] sw_stable;
    logic             confirm_pulse;
    logic             confirm_pending;

    int n_chk = 0;
    int n_err = 0;

    switch_debounce #(.WIDTH(WIDTH), .DB_CYCLES(DB)) dut (
        .clk             (clk),
        .rst             (rst),
        .sw_raw          (sw_raw),
        .btn_raw         (btn_raw),
        .ack             (ack),
        .sw_stable       (sw_stable),
        .confirm_pulse   (confirm_pulse),
        .confirm_pending (confirm_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one active edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b0;
        sw_raw  = '0;
        btn_raw = 1'b0;
        ack     = 1'b0;
        #12;
        chk("rst_sw", 32'(sw_stable), 32'h0);
        chk("rst_pulse", 32'(confirm_pulse), 32'h0);
        chk("rst_pend", 32'(confirm_pending), 32'h0);

        // Reset release with a vector held: commit lands on edge 7.
        sw_raw = 16'hA5C3;
        tick();
        rst = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("a5c3_hold", 32'(sw_stable), 32'h0);
            chk("a5c3_nopulse", 32'(confirm_pulse), 32'h0);
        end
        tick();
        chk("a5c3_commit", 32'(sw_stable), 32'hA5C3);

        sw_raw = 16'h0000;
        for (int i = 0; i < 8; i++) tick();
        chk("zero_commit", 32'(sw_stable), 32'h0);

        // Toggle every 2 cycles: window never completes.
        for (int i = 0; i < 20; i++) begin
            sw_raw = ((i / 2) % 2 == 0) ? 16'h0001 : 16'h0000;
            tick();
            chk("toggle_hold", 32'(sw_stable), 32'h0);
        end
        sw_raw = 16'h0001;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("tog_settle", 32'(sw_stable), 32'h0);
        end
        tick();
        chk("tog_commit", 32'(sw_stable), 32'h0001);

        // Change lands exactly when the window would complete: no commit of 00F0.
        sw_raw = 16'h00F0;
        for (int i = 0; i < 4; i++) tick();
        sw_raw = 16'h0F00;
        for (int i = 5; i <= 10; i++) begin
            tick();
            chk("boundary_hold", 32'(sw_stable), 32'h0001);
        end
        tick();
        chk("boundary_commit", 32'(sw_stable), 32'h0F00);

        // Short press (3 cycles) is rejected.
        btn_raw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("short_nopulse", 32'(confirm_pulse), 32'h0);
        end
        btn_raw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("short_nopulse", 32'(confirm_pulse), 32'h0);
        end
        chk("short_nopend", 32'(confirm_pending), 32'h0);

        // Long press: one pulse 7 edges after start, pending follows.
        btn_raw = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("long_pulse", 32'(confirm_pulse), (i == 7) ? 32'h1 : 32'h0);
            if (i >= 8) chk("long_pend", 32'(confirm_pending), 32'h1);
        end

        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("lone_ack_clr", 32'(confirm_pending), 32'h0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("ack_idle_noeffect", 32'(confirm_pending), 32'h0);

        // Release bounce while PRESSED: only the final press pulses.
        btn_raw = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rel_nopulse", 32'(confirm_pulse), 32'h0);
        end
        btn_raw = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rel_nopulse", 32'(confirm_pulse), 32'h0);
        end
        btn_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rel_nopulse", 32'(confirm_pulse), 32'h0);
        end
        btn_raw = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("rel_pulse", 32'(confirm_pulse), (i == 7) ? 32'h1 : 32'h0);
            ack = (i == 7);
            if (i == 8) chk("ack_vs_pulse", 32'(confirm_pending), 32'h1);
        end
        ack = 1'b0;
        chk("pend_kept", 32'(confirm_pending), 32'h1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("later_ack_clr", 32'(confirm_pending), 32'h0);

        // Reset in the middle of PRESS_WAIT with FFFF committed.
        sw_raw  = 16'hFFFF;
        btn_raw = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("ffff_commit", 32'(sw_stable), 32'hFFFF);
        btn_raw = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("pw_nopulse", 32'(confirm_pulse), 32'h0);
        end
        rst = 1'b0;
        #1;
        chk("async_sw", 32'(sw_stable), 32'h0);
        chk("async_pulse", 32'(confirm_pulse), 32'h0);
        chk("async_pend", 32'(confirm_pending), 32'h0);
        tick();
        tick();
        chk("inrst_pulse", 32'(confirm_pulse), 32'h0);
        rst = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("post_rst_sw", 32'(sw_stable), 32'h0);
            chk("post_rst_pulse", 32'(confirm_pulse), 32'h0);
        end
        tick();
        chk("post_rst_sw7", 32'(sw_stable), 32'hFFFF);
        chk("post_rst_pulse7", 32'(confirm_pulse), 32'h1);
        tick();
        chk("post_rst_pulse8", 32'(confirm_pulse), 32'h0);
        chk("post_rst_pend8", 32'(confirm_pending), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/switch_debounce.md
# switch_debounce

Input-conditioning stage between the board's 16 slide switches plus confirm push-button and the memory-mapped switch read port. It synchronises the raw pins into `clk`, debounces the switch vector as a group and the button separately, and produces a stable 16-bit switch value. It also produces a one-cycle confirm pulse and a sticky confirm flag, which the CPU clears through the IO port.

## Interface
Parameters:
- `WIDTH`, 16: switch vector width.
- `DB_CYCLES`, 200000: consecutive stable cycles required before committing a new value (2 ms at 100 MHz); legal range ≥ 2.
- Counter width is a derived localparam, `$clog2(DB_CYCLES)`; it is not a parameter.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: reset, asynchronous, active-low.
- `sw_raw`  in  WIDTH: raw switch pins, asynchronous to `clk`.
- `btn_raw`  in  1: raw confirm button, active-high, asynchronous.
- `ack`  in  1: one-cycle CPU acknowledge; clears `confirm_pending`.
- `sw_stable`  out  WIDTH: debounced switch vector; this feeds the switch read port's `switch_input`.
- `confirm_pulse`  out  1: one-cycle pulse on each debounced button press.
- `confirm_pending`  out  1: sticky press flag; this feeds the read port's `confirmation`.

## Operation
- Reset (`rst`=0, asynchronous): sync flops, candidate, counters, `sw_stable`, `confirm_pulse` and `confirm_pending` all go to 0. The button FSM goes to IDLE.
- Synchronisation: every input bit passes through two flops (`s1`→`s2`). All logic below uses the `s2` values.

Switch path (group debounce):
- If `sw_s2` ≠ `cand`: load `cand` ← `sw_s2` and set `sw_cnt` ← 0.
- Else if `sw_cnt` == DB_CYCLES−1: `sw_stable` ← `cand`. The counter holds at DB_CYCLES−1, so the commit repeats each cycle with the same value.
- Else: `sw_cnt` increments.
- Any bit change restarts the whole window. Partial or glitching vectors never reach `sw_stable`.

Button FSM (`btn_cnt` is shared across states):
- IDLE: if `btn_s2`=1, go to PRESS_WAIT with `btn_cnt`=0.
- PRESS_WAIT:
  - If `btn_s2`=0, go to IDLE.
  - Else if `btn_cnt`==DB_CYCLES−1, go to PRESSED and register `confirm_pulse`=1.
  - Else `btn_cnt`++.
- PRESSED: if `btn_s2`=0, go to RELEASE_WAIT with `btn_cnt`=0. Otherwise stay.
- RELEASE_WAIT:
  - If `btn_s2`=1, return to PRESSED with no pulse (release bounce).
  - Else if `btn_cnt`==DB_CYCLES−1, go to IDLE.
  - Else `btn_cnt`++.
- `confirm_pulse` is 1 only for the cycle after the PRESS_WAIT→PRESSED transition and is 0 otherwise. Holding the button produces exactly one pulse.
- `confirm_pending`: set by `confirm_pulse`, cleared by `ack`. If both occur in the same cycle, set wins and the flag stays 1. `ack` while the flag is 0 has no effect.

## Timing
- All state updates on the posedge of `clk`. Reset is the only asynchronous path.
- Switch latency: raw value stable before edge 1 → `sw_stable` updates on edge DB_CYCLES+3.
  - Edges 1–2: synchroniser.
  - Edge 3: `cand` load.
  - Edges 4 to DB_CYCLES+2: count.
  - Edge DB_CYCLES+3: commit.
- Button latency: raw press stable before edge 1 → `confirm_pulse` high for the cycle following edge DB_CYCLES+3. `confirm_pending` rises on edge DB_CYCLES+4.
- Release: the button must be low for DB_CYCLES+3 edges before the FSM returns to IDLE and a new press can be accepted.
- Bounce at the window boundary: a change sampled on the same edge the counter reaches DB_CYCLES−1 restarts the window; the commit does not happen.
- Reset release with inputs held:
  - `sw_stable` re-commits after DB_CYCLES+3 edges. A held-at-zero vector commits 0, with no visible change.
  - A held button produces a fresh pulse.
- Counters never wrap: they saturate at DB_CYCLES−1.

## Test plan (DB_CYCLES=4)
- Reset then `sw_raw`=16'hA5C3 held → `sw_stable`=0 through edge 6, =16'hA5C3 from edge 7. `confirm_pulse` stays 0.
- `sw_raw` toggles 16'h0001/16'h0000 every 2 cycles for 20 cycles, then holds 16'h0001 → `sw_stable` stays 0 during toggling and becomes 16'h0001 exactly 7 edges after the final change.
- `btn_raw` high for 3 cycles, low, then high for 10 cycles → no pulse for the short press. Exactly one 1-cycle pulse for the long press, 7 edges after its start. `confirm_pending`=1 afterwards.
- Release bounce: in PRESSED, drive `btn_raw` low 2 cycles, high 2, low 10, then high 10 → exactly one additional pulse, and only from the final press.
- `ack` asserted on the same cycle as `confirm_pulse` → `confirm_pending` stays 1. A later lone `ack` → `confirm_pending`=0 on the next edge.
- Assert `rst`=0 mid-PRESS_WAIT with `sw_stable`=16'hFFFF → all outputs 0 immediately, with no pulse. After release with inputs held, `sw_stable`=16'hFFFF at edge 7 and one pulse at edge 7.
